// File: rtl/sram_ecc_pkg.sv
// Shared types and sizes for the ECC SRAM front-end and the memory it drives.
package sram_ecc_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RESP,
        WR,
        SCRUB,
        FLUSH
    } state_t;

endpackage

// File: rtl/sram_ecc_ctrl_scrub_timer.sv
// Free-running scrub interval timer; raises a single, non-accumulating
// scrub_pending flag every SCRUB_INTERVAL cycles while scrubbing is enabled.
module scrub_timer #(
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic scrub_en,
    input  logic clr_pending,
    output logic scrub_pending
);

    localparam int CNT_W = $clog2(SCRUB_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCRUB_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             pending_reg;
    logic             terminal;

    assign terminal      = (cnt_reg == CNT_LAST);
    assign scrub_pending = pending_reg;

    // Count 0..SCRUB_INTERVAL-1; a terminal count while already pending is dropped.
    always_ff @(posedge clk) begin
        if (rst || !scrub_en) begin
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            cnt_reg <= terminal ? '0 : cnt_reg + 1'b1;
            if (clr_pending) begin
                pending_reg <= 1'b0;
            end else if (terminal) begin
                pending_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_ecc_ctrl.sv
// Host request serialiser and background scrubber in front of the Hamming
// protected SRAM. A FLUSH read is inserted before any write that follows a
// read, so the memory's deferred correction write-back is committed first and
// cannot override the host write on the same edge.
module sram_ecc_ctrl
    import sram_ecc_pkg::*;
#(
    parameter int ADDR_W         = MEM_ADDR_W,
    parameter int DATA_W         = MEM_DATA_W,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              scrub_en,
    output logic              scrub_wrap,
    output logic              mem_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [DATA_W-1:0] req_wdata_reg;
    logic              wr_pending_reg;   // a write is parked behind a FLUSH
    logic              rd_dirty_reg;     // memory may hold a pending write-back
    logic [ADDR_W-1:0] last_rd_addr_reg;
    logic [ADDR_W-1:0] scrub_addr_reg;
    logic              scrub_pending;
    logic              clr_pending;

    assign clr_pending = (state_reg == SCRUB);

    scrub_timer #(
        .SCRUB_INTERVAL(SCRUB_INTERVAL)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .scrub_en     (scrub_en),
        .clr_pending  (clr_pending),
        .scrub_pending(scrub_pending)
    );

    // Next-state decode; host requests take priority over a pending scrub.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (!req_we) begin
                        state_next = RD;
                    end else begin
                        state_next = rd_dirty_reg ? FLUSH : WR;
                    end
                end else if (scrub_pending) begin
                    state_next = SCRUB;
                end
            end
            RD:      state_next = RESP;
            RESP:    state_next = IDLE;
            WR:      state_next = IDLE;
            SCRUB:   state_next = FLUSH;
            FLUSH:   state_next = wr_pending_reg ? WR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, latched request and scrub bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            req_addr_reg     <= '0;
            req_wdata_reg    <= '0;
            wr_pending_reg   <= 1'b0;
            rd_dirty_reg     <= 1'b0;
            last_rd_addr_reg <= '0;
            scrub_addr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        req_addr_reg   <= req_addr;
                        req_wdata_reg  <= req_wdata;
                        wr_pending_reg <= req_we && rd_dirty_reg;
                    end
                end
                RD: begin
                    rd_dirty_reg     <= 1'b1;
                    last_rd_addr_reg <= req_addr_reg;
                end
                SCRUB: begin
                    last_rd_addr_reg <= scrub_addr_reg;
                    scrub_addr_reg   <= scrub_addr_reg + 1'b1;
                end
                FLUSH: begin
                    rd_dirty_reg   <= 1'b0;
                    wr_pending_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state and latched fields only.
    always_comb begin
        req_ready  = (state_reg == IDLE);
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        scrub_wrap = 1'b0;
        mem_enable = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            RD: begin
                mem_enable = 1'b1;
                mem_addr   = req_addr_reg;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = mem_rdata;
            end
            WR: begin
                mem_enable = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = req_addr_reg;
                mem_wdata  = req_wdata_reg;
            end
            SCRUB: begin
                mem_enable = 1'b1;
                mem_addr   = scrub_addr_reg;
                scrub_wrap = &scrub_addr_reg;
            end
            FLUSH: begin
                mem_enable = 1'b1;
                mem_addr   = last_rd_addr_reg;
            end
            default: ;
        endcase
    end

endmodule
